// File: rtl/stream_split.sv
// stream_split: splits each accepted input beat into a left and a right field,
// each buffered in its own FIFO so either output can drain while the other stalls.

// Single-clock FIFO with an occupancy counter; head data reads as zero when empty.
module stream_split_fifo #(
    parameter int W       = 8,
    parameter int ADDR_SZ = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  logic [W-1:0]     i_data,
    input  logic             i_pop,
    output logic [W-1:0]     o_data,
    output logic [ADDR_SZ:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int DEPTH = 1 << ADDR_SZ;
    localparam logic [ADDR_SZ:0]   FULL_CNT = {1'b1, {ADDR_SZ{1'b0}}};
    localparam logic [ADDR_SZ:0]   CNT_ONE  = (ADDR_SZ+1)'(1);
    localparam logic [ADDR_SZ-1:0] PTR_ONE  = ADDR_SZ'(1);

    logic [W-1:0]       r_mem [DEPTH];
    logic [ADDR_SZ-1:0] r_wr_ptr;
    logic [ADDR_SZ-1:0] r_rd_ptr;
    logic [ADDR_SZ:0]   r_count;

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Pointers are ADDR_SZ bits wide, so incrementing wraps modulo DEPTH.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

module stream_split #(
    parameter int LEFT_WIDTH   = 8,
    parameter int RIGHT_WIDTH  = 8,
    parameter int FIFO_ADDR_SZ = 1,
    parameter int IN_WIDTH     = LEFT_WIDTH + RIGHT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_valid,
    output logic                    i_ready,
    input  logic [IN_WIDTH-1:0]     i_data,
    output logic                    o_left_valid,
    input  logic                    o_left_ready,
    output logic [LEFT_WIDTH-1:0]   o_left_data,
    output logic                    o_right_valid,
    input  logic                    o_right_ready,
    output logic [RIGHT_WIDTH-1:0]  o_right_data,
    output logic [FIFO_ADDR_SZ:0]   o_left_count,
    output logic [FIFO_ADDR_SZ:0]   o_right_count
);
    logic w_accept;
    logic w_left_full, w_right_full;
    logic w_left_empty, w_right_empty;
    logic w_left_pop, w_right_pop;

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // Valid never depends on ready; an input beat goes to both FIFOs or neither.
    assign i_ready       = reset_n && !w_left_full && !w_right_full;
    assign w_accept      = i_valid && i_ready;
    assign o_left_valid  = !w_left_empty;
    assign o_right_valid = !w_right_empty;
    assign w_left_pop    = o_left_valid && o_left_ready;
    assign w_right_pop   = o_right_valid && o_right_ready;

    stream_split_fifo #(
        .W       (LEFT_WIDTH),
        .ADDR_SZ (FIFO_ADDR_SZ)
    ) u_left_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_accept),
        .i_data  (i_data[IN_WIDTH-1:RIGHT_WIDTH]),
        .i_pop   (w_left_pop),
        .o_data  (o_left_data),
        .o_count (o_left_count),
        .o_full  (w_left_full),
        .o_empty (w_left_empty)
    );

    stream_split_fifo #(
        .W       (RIGHT_WIDTH),
        .ADDR_SZ (FIFO_ADDR_SZ)
    ) u_right_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_accept),
        .i_data  (i_data[RIGHT_WIDTH-1:0]),
        .i_pop   (w_right_pop),
        .o_data  (o_right_data),
        .o_count (o_right_count),
        .o_full  (w_right_full),
        .o_empty (w_right_empty)
    );
endmodule

// File: tb/tb_stream_split.sv
// Directed testbench for stream_split with default parameters (8/8, depth 2).
module tb_stream_split;
    logic        clk;
    logic        reset_n;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_data;
    logic        o_left_valid, o_left_ready;
    logic [7:0]  o_left_data;
    logic        o_right_valid, o_right_ready;
    logic [7:0]  o_right_data;
    logic [1:0]  o_left_count, o_right_count;

    int checks;
    int failures;
    logic [15:0] exp_q[$];

    stream_split dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_valid       (i_valid),
        .i_ready       (i_ready),
        .i_data        (i_data),
        .o_left_valid  (o_left_valid),
        .o_left_ready  (o_left_ready),
        .o_left_data   (o_left_data),
        .o_right_valid (o_right_valid),
        .o_right_ready (o_right_ready),
        .o_right_data  (o_right_data),
        .o_left_count  (o_left_count),
        .o_right_count (o_right_count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance to just after the next active edge; drive and sample there.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset_n       = 1'b0;
        i_valid       = 1'b0;
        i_data        = 16'hFFFF;
        o_left_ready  = 1'b0;
        o_right_ready = 1'b0;
        #1;
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL rst_i_ready got=%b exp=0", i_ready); end
        checks++; if ({o_left_valid, o_right_valid} !== 2'b00) begin failures++; $display("FAIL rst_valids got=%b exp=00", {o_left_valid, o_right_valid}); end
        checks++; if ({o_left_data, o_right_data} !== 16'h0000) begin failures++; $display("FAIL rst_data got=%h exp=0000", {o_left_data, o_right_data}); end
        checks++; if ({o_left_count, o_right_count} !== 4'h0) begin failures++; $display("FAIL rst_counts got=%h exp=0", {o_left_count, o_right_count}); end
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL rst_release_ready got=%b exp=1", i_ready); end
        checks++; if ({o_left_valid, o_right_valid} !== 2'b00) begin failures++; $display("FAIL rst_release_valids got=%b exp=00", {o_left_valid, o_right_valid}); end
    endtask

    task automatic test_single_beat();
        o_left_ready  = 1'b1;
        o_right_ready = 1'b1;
        i_valid       = 1'b1;
        i_data        = 16'hA55A;
        tick();
        i_valid = 1'b0;
        i_data  = 16'h0000;
        checks++; if ({o_left_valid, o_right_valid} !== 2'b11) begin failures++; $display("FAIL sb_valids got=%b exp=11", {o_left_valid, o_right_valid}); end
        checks++; if (o_left_data !== 8'hA5) begin failures++; $display("FAIL sb_left_data got=%h exp=a5", o_left_data); end
        checks++; if (o_right_data !== 8'h5A) begin failures++; $display("FAIL sb_right_data got=%h exp=5a", o_right_data); end
        tick();
        checks++; if ({o_left_valid, o_right_valid} !== 2'b00) begin failures++; $display("FAIL sb_valids_after got=%b exp=00", {o_left_valid, o_right_valid}); end
        checks++; if ({o_left_data, o_right_data} !== 16'h0000) begin failures++; $display("FAIL sb_data_after got=%h exp=0000", {o_left_data, o_right_data}); end
    endtask

    task automatic test_right_stall();
        o_left_ready  = 1'b1;
        o_right_ready = 1'b0;
        i_valid       = 1'b1;
        i_data        = 16'h0102;
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL rs_ready0 got=%b exp=1", i_ready); end
        tick();
        checks++; if (o_left_data !== 8'h01) begin failures++; $display("FAIL rs_left_01 got=%h exp=01", o_left_data); end
        checks++; if ({o_left_count, o_right_count} !== 4'b0101) begin failures++; $display("FAIL rs_counts1 got=%b exp=0101", {o_left_count, o_right_count}); end
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL rs_ready1 got=%b exp=1", i_ready); end
        i_data = 16'h0304;
        tick();
        checks++; if (o_left_data !== 8'h03) begin failures++; $display("FAIL rs_left_03 got=%h exp=03", o_left_data); end
        checks++; if ({o_left_count, o_right_count} !== 4'b0110) begin failures++; $display("FAIL rs_counts2 got=%b exp=0110", {o_left_count, o_right_count}); end
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL rs_ready_full got=%b exp=0", i_ready); end
        i_data = 16'h0506;
        tick();
        checks++; if (o_left_valid !== 1'b0) begin failures++; $display("FAIL rs_left_drained got=%b exp=0", o_left_valid); end
        checks++; if ({o_left_count, o_right_count} !== 4'b0010) begin failures++; $display("FAIL rs_counts3 got=%b exp=0010", {o_left_count, o_right_count}); end
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL rs_ready_held got=%b exp=0", i_ready); end
        checks++; if (o_right_data !== 8'h02) begin failures++; $display("FAIL rs_right_head got=%h exp=02", o_right_data); end
        o_right_ready = 1'b1;
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL rs_ready_same_cycle got=%b exp=0", i_ready); end
        tick();
        checks++; if (o_right_data !== 8'h04) begin failures++; $display("FAIL rs_right_04 got=%h exp=04", o_right_data); end
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL rs_ready_reopen got=%b exp=1", i_ready); end
        checks++; if ({o_left_count, o_right_count} !== 4'b0001) begin failures++; $display("FAIL rs_counts4 got=%b exp=0001", {o_left_count, o_right_count}); end
        tick();
        i_valid = 1'b0;
        checks++; if ({o_left_data, o_right_data} !== 16'h0506) begin failures++; $display("FAIL rs_last_beat got=%h exp=0506", {o_left_data, o_right_data}); end
        checks++; if ({o_left_count, o_right_count} !== 4'b0101) begin failures++; $display("FAIL rs_counts5 got=%b exp=0101", {o_left_count, o_right_count}); end
        tick();
        checks++; if ({o_left_valid, o_right_valid} !== 2'b00) begin failures++; $display("FAIL rs_empty got=%b exp=00", {o_left_valid, o_right_valid}); end
    endtask

    task automatic test_full_stall();
        o_left_ready  = 1'b0;
        o_right_ready = 1'b0;
        i_valid       = 1'b1;
        i_data        = 16'h1122;
        tick();
        i_data = 16'h3344;
        tick();
        i_data = 16'h5566;
        checks++; if ({o_left_count, o_right_count} !== 4'b1010) begin failures++; $display("FAIL fs_counts got=%b exp=1010", {o_left_count, o_right_count}); end
        checks++; if (i_ready !== 1'b0) begin failures++; $display("FAIL fs_ready got=%b exp=0", i_ready); end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++; if ({o_left_valid, o_left_data, o_right_valid, o_right_data} !== {1'b1, 8'h11, 1'b1, 8'h22}) begin
                failures++; $display("FAIL fs_stable_%0d got=%b/%h/%b/%h exp=1/11/1/22", k, o_left_valid, o_left_data, o_right_valid, o_right_data);
            end
        end
        i_valid       = 1'b0;
        o_left_ready  = 1'b1;
        o_right_ready = 1'b1;
        tick();
        checks++; if ({o_left_data, o_right_data} !== 16'h3344) begin failures++; $display("FAIL fs_second got=%h exp=3344", {o_left_data, o_right_data}); end
        tick();
        checks++; if ({o_left_count, o_right_count} !== 4'b0000) begin failures++; $display("FAIL fs_drained got=%b exp=0000", {o_left_count, o_right_count}); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_beat;
        o_left_ready  = 1'b1;
        o_right_ready = 1'b1;
        i_valid       = 1'b1;
        for (int k = 0; k < 16; k++) begin
            i_data = {k[7:0], k[7:0]};
            checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL tp_ready_%0d got=%b exp=1", k, i_ready); end
            exp_q.push_back({k[7:0], k[7:0]});
            tick();
            exp_beat = exp_q.pop_front();
            checks++; if ({o_left_valid, o_right_valid, o_left_data, o_right_data} !== {2'b11, exp_beat}) begin
                failures++; $display("FAIL tp_beat_%0d got=%b%b/%h%h exp=11/%h", k, o_left_valid, o_right_valid, o_left_data, o_right_data, exp_beat);
            end
            checks++; if ({o_left_count, o_right_count} !== 4'b0101) begin failures++; $display("FAIL tp_count_%0d got=%b exp=0101", k, {o_left_count, o_right_count}); end
        end
        i_valid = 1'b0;
        tick();
        checks++; if ({o_left_valid, o_right_valid} !== 2'b00) begin failures++; $display("FAIL tp_end got=%b exp=00", {o_left_valid, o_right_valid}); end
    endtask

    task automatic test_mid_reset();
        o_left_ready  = 1'b0;
        o_right_ready = 1'b1;
        i_valid       = 1'b1;
        i_data        = 16'hAABB;
        tick();
        i_data = 16'hCCDD;
        tick();
        i_valid = 1'b0;
        checks++; if ({o_left_count, o_right_count} !== 4'b1001) begin failures++; $display("FAIL mr_pre_counts got=%b exp=1001", {o_left_count, o_right_count}); end
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if ({o_left_valid, o_right_valid, i_ready} !== 3'b000) begin failures++; $display("FAIL mr_valids got=%b exp=000", {o_left_valid, o_right_valid, i_ready}); end
        checks++; if ({o_left_data, o_right_data} !== 16'h0000) begin failures++; $display("FAIL mr_data got=%h exp=0000", {o_left_data, o_right_data}); end
        checks++; if ({o_left_count, o_right_count} !== 4'b0000) begin failures++; $display("FAIL mr_counts got=%b exp=0000", {o_left_count, o_right_count}); end
        tick();
        reset_n = 1'b1;
        #1;
        checks++; if (i_ready !== 1'b1) begin failures++; $display("FAIL mr_release_ready got=%b exp=1", i_ready); end
        tick();
        checks++; if ({o_left_valid, o_right_valid} !== 2'b00) begin failures++; $display("FAIL mr_no_residue got=%b exp=00", {o_left_valid, o_right_valid}); end
    endtask

    task automatic test_simul_push_pop();
        o_left_ready  = 1'b0;
        o_right_ready = 1'b0;
        i_valid       = 1'b1;
        i_data        = 16'h1234;
        tick();
        i_data        = 16'h5678;
        o_left_ready  = 1'b1;
        o_right_ready = 1'b1;
        checks++; if ({o_left_data, o_right_data} !== 16'h1234) begin failures++; $display("FAIL pp_old_data got=%h exp=1234", {o_left_data, o_right_data}); end
        tick();
        i_valid = 1'b0;
        checks++; if ({o_left_count, o_right_count} !== 4'b0101) begin failures++; $display("FAIL pp_counts got=%b exp=0101", {o_left_count, o_right_count}); end
        checks++; if ({o_left_data, o_right_data} !== 16'h5678) begin failures++; $display("FAIL pp_new_data got=%h exp=5678", {o_left_data, o_right_data}); end
        tick();
        checks++; if ({o_left_count, o_right_count} !== 4'b0000) begin failures++; $display("FAIL pp_drained got=%b exp=0000", {o_left_count, o_right_count}); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_beat();
        test_right_stall();
        apply_reset();
        test_full_stall();
        test_back_to_back();
        test_mid_reset();
        test_simul_push_pop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
